// File: rtl/clock_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// clock_ctrl_pkg
// Shared definitions for the time-setting sequencer: set-mode state encoding,
// wrap limits for the edited hour/minute values, blink mask patterns and the
// wrap-around increment helpers.
// ---------------------------------------------------------------------------
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_COMMIT   = 2'd3
    } mode_state_t;

    localparam logic [4:0] HOUR_MAX   = 5'd23;
    localparam logic [5:0] MINUTE_MAX = 6'd59;

    localparam logic [3:0] BLINK_NONE   = 4'b0000;
    localparam logic [3:0] BLINK_HOUR   = 4'b1100;
    localparam logic [3:0] BLINK_MINUTE = 4'b0011;

    function automatic logic [4:0] hour_incr(input logic [4:0] v);
        return (v == HOUR_MAX) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [5:0] minute_incr(input logic [5:0] v);
        return (v == MINUTE_MAX) ? 6'd0 : v + 6'd1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
// Synchronises a raw push button into the clock domain, accepts a new level
// only after DEBOUNCE_CYCLES consecutive samples that differ from the current
// accepted level, and emits a one-cycle press pulse on each accepted 0->1 edge.
// Raw edge to press pulse: DEBOUNCE_CYCLES+3 clock cycles.
// Ports:
//   clock    in   system clock
//   reset    in   asynchronous active-low reset
//   i_raw    in   raw button level (asynchronous)
//   o_level  out  debounced button level
//   o_press  out  one-cycle pulse on accepted rising edge
// ---------------------------------------------------------------------------
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_sync0;
    logic          r_sync1;
    logic          r_level;
    logic          r_level_prev;
    logic          r_press;
    logic [CW-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync0      <= 1'b0;
            r_sync1      <= 1'b0;
            r_level      <= 1'b0;
            r_level_prev <= 1'b0;
            r_press      <= 1'b0;
            r_count      <= '0;
        end else begin
            r_sync0 <= i_raw;
            r_sync1 <= r_sync0;
            // Count only an unbroken run of samples that disagree with the
            // accepted level; a single agreeing sample starts the run over.
            if (r_sync1 == r_level) begin
                r_count <= '0;
            end else if (r_count == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_count <= '0;
                r_level <= r_sync1;
            end else begin
                r_count <= r_count + 1'b1;
            end
            r_level_prev <= r_level;
            r_press      <= r_level & ~r_level_prev;
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/clock_set_controller.sv
// ---------------------------------------------------------------------------
// clock_set_controller
// Time-setting sequencer for the hour/minute/second datapath. Debounced mode
// and inc buttons drive a RUN -> SET_HOUR -> SET_MIN -> COMMIT state machine
// that freezes counting, edits working copies of hour/minute, commits them
// with one-cycle load strobes, and requests digit blinking while editing.
// A set state is abandoned without commit after TIMEOUT_TICKS idle ticks.
// Optional feature macro: CLOCK_SET_AUTOREPEAT_EN -- inc held for at least one
// tick in a set state repeats the increment every REPEAT_CYCLES cycles.
// Ports:
//   clock, reset                 clock / asynchronous active-low reset
//   btn_mode, btn_inc            raw buttons, active high
//   tick                         one-cycle 1 Hz strobe
//   hour_in, minute_in           current datapath time
//   run_en                       1 = datapath counts
//   load_hour, load_minute       commit strobes for hour_val / minute_val
//   clear_seconds                commit strobe clearing seconds/prescaler
//   hour_val, minute_val         edited values
//   blink_mask                   [3:2] hour digits, [1:0] minute digits
//   mode_state                   current FSM state
// ---------------------------------------------------------------------------
module clock_set_controller
    import clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int TIMEOUT_TICKS   = 30,
    parameter int REPEAT_CYCLES   = 8192
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       tick,
    input  logic [4:0] hour_in,
    input  logic [5:0] minute_in,
    output logic       run_en,
    output logic       load_hour,
    output logic       load_minute,
    output logic       clear_seconds,
    output logic [4:0] hour_val,
    output logic [5:0] minute_val,
    output logic [3:0] blink_mask,
    output logic [1:0] mode_state
);

    localparam int IW = $clog2(TIMEOUT_TICKS + 1);

    mode_state_t   r_state;
    mode_state_t   w_state_next;
    logic [4:0]    r_hour_val;
    logic [4:0]    w_hour_next;
    logic [5:0]    r_minute_val;
    logic [5:0]    w_minute_next;
    logic [IW-1:0] r_idle;
    logic [IW-1:0] w_idle_next;
    logic          r_phase;
    logic          w_phase_next;

    logic w_mode_press;
    logic w_mode_level;
    logic w_inc_press;
    logic w_inc_level;
    logic w_inc_evt;
    logic w_in_set;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clock   (clock),
        .reset   (reset),
        .i_raw   (btn_mode),
        .o_level (w_mode_level),
        .o_press (w_mode_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
        .clock   (clock),
        .reset   (reset),
        .i_raw   (btn_inc),
        .o_level (w_inc_level),
        .o_press (w_inc_press)
    );

    assign w_in_set = (r_state == ST_SET_HOUR) || (r_state == ST_SET_MIN);

`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    logic          r_rep_armed;
    logic [RW-1:0] r_rep_cnt;
    logic          w_repeat;

    // Arms on the first tick seen while inc is held in a set state; from then
    // on a repeat fires every REPEAT_CYCLES cycles until release or exit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rep_armed <= 1'b0;
            r_rep_cnt   <= '0;
        end else if (!w_in_set || !w_inc_level || w_mode_press) begin
            r_rep_armed <= 1'b0;
            r_rep_cnt   <= '0;
        end else if (!r_rep_armed) begin
            r_rep_armed <= tick;
            r_rep_cnt   <= '0;
        end else if (w_repeat) begin
            r_rep_cnt <= '0;
        end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end

    assign w_repeat  = r_rep_armed && (r_rep_cnt == RW'(REPEAT_CYCLES - 1));
    assign w_inc_evt = w_inc_press | w_repeat;

    logic w_unused_levels;
    assign w_unused_levels = &{1'b0, w_mode_level};
`else
    assign w_inc_evt = w_inc_press;

    logic w_unused_levels;
    assign w_unused_levels = &{1'b0, w_mode_level, w_inc_level, REPEAT_CYCLES[0]};
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_RUN;
            r_hour_val   <= 5'd0;
            r_minute_val <= 6'd0;
            r_idle       <= '0;
            r_phase      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_hour_val   <= w_hour_next;
            r_minute_val <= w_minute_next;
            r_idle       <= w_idle_next;
            r_phase      <= w_phase_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_hour_next   = r_hour_val;
        w_minute_next = r_minute_val;
        w_idle_next   = r_idle;
        w_phase_next  = r_phase;
        run_en        = 1'b1;
        load_hour     = 1'b0;
        load_minute   = 1'b0;
        clear_seconds = 1'b0;
        blink_mask    = BLINK_NONE;

        case (r_state)
            ST_RUN: begin
                if (w_mode_press) begin
                    w_hour_next   = hour_in;
                    w_minute_next = minute_in;
                    w_state_next  = ST_SET_HOUR;
                    w_idle_next   = '0;
                    w_phase_next  = 1'b0;
                end
            end

            ST_SET_HOUR, ST_SET_MIN: begin
                run_en = 1'b0;
                if (r_phase) begin
                    blink_mask = (r_state == ST_SET_HOUR) ? BLINK_HOUR : BLINK_MINUTE;
                end
                // mode has priority over a coincident inc; a press swallows a
                // coincident tick as far as the idle timer is concerned.
                if (w_mode_press) begin
                    w_state_next = (r_state == ST_SET_HOUR) ? ST_SET_MIN : ST_COMMIT;
                    w_idle_next  = '0;
                    w_phase_next = 1'b0;
                end else begin
                    if (tick) begin
                        w_phase_next = ~r_phase;
                    end
                    if (w_inc_evt) begin
                        w_idle_next = '0;
                        if (r_state == ST_SET_HOUR) begin
                            w_hour_next = hour_incr(r_hour_val);
                        end else begin
                            w_minute_next = minute_incr(r_minute_val);
                        end
                    end else if (tick) begin
                        if (r_idle == IW'(TIMEOUT_TICKS - 1)) begin
                            w_state_next = ST_RUN;
                            w_idle_next  = '0;
                        end else begin
                            w_idle_next = r_idle + 1'b1;
                        end
                    end
                end
            end

            ST_COMMIT: begin
                run_en        = 1'b0;
                load_hour     = 1'b1;
                load_minute   = 1'b1;
                clear_seconds = 1'b1;
                w_state_next  = ST_RUN;
            end

            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    assign hour_val   = r_hour_val;
    assign minute_val = r_minute_val;
    assign mode_state = r_state;

endmodule

// File: tb/tb_clock_set_controller.sv
// ---------------------------------------------------------------------------
// tb_clock_set_controller
// Self-checking bench for clock_set_controller (DEBOUNCE_CYCLES=4,
// TIMEOUT_TICKS=3, REPEAT_CYCLES=16). Expected commit values are queued when
// the committing stimulus is driven and compared when the strobes appear.
// ---------------------------------------------------------------------------
module tb_clock_set_controller;

    localparam int DEB = 4;
    localparam int HOLD = DEB + 6;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       tick = 1'b0;
    logic [4:0] hour_in = 5'd0;
    logic [5:0] minute_in = 6'd0;
    logic       run_en;
    logic       load_hour;
    logic       load_minute;
    logic       clear_seconds;
    logic [4:0] hour_val;
    logic [5:0] minute_val;
    logic [3:0] blink_mask;
    logic [1:0] mode_state;

    typedef struct {
        logic [4:0] hour;
        logic [5:0] minute;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    clock_set_controller #(
        .DEBOUNCE_CYCLES (DEB),
        .TIMEOUT_TICKS   (3),
        .REPEAT_CYCLES   (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .btn_mode      (btn_mode),
        .btn_inc       (btn_inc),
        .tick          (tick),
        .hour_in       (hour_in),
        .minute_in     (minute_in),
        .run_en        (run_en),
        .load_hour     (load_hour),
        .load_minute   (load_minute),
        .clear_seconds (clear_seconds),
        .hour_val      (hour_val),
        .minute_val    (minute_val),
        .blink_mask    (blink_mask),
        .mode_state    (mode_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press(input logic do_mode, input logic do_inc);
        btn_mode = do_mode;
        btn_inc  = do_inc;
        wait_cycles(HOLD);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        wait_cycles(HOLD);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        wait_cycles(1);
        tick = 1'b0;
    endtask

    // Commit monitor: every strobe must match a queued expectation.
    always @(negedge clock) begin
        if (load_hour || load_minute || clear_seconds) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {29'd0, load_hour, load_minute, clear_seconds}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("commit_strobes", {29'd0, load_hour, load_minute, clear_seconds}, 32'd7);
                check("commit_hour", {27'd0, hour_val}, {27'd0, e.hour});
                check("commit_minute", {26'd0, minute_val}, {26'd0, e.minute});
                check("commit_state", {30'd0, mode_state}, 32'd3);
                check("commit_run_en", {31'd0, run_en}, 32'd0);
            end
        end
    end

    initial begin
        // Reset state
        wait_cycles(3);
        check("rst_state", {30'd0, mode_state}, 32'd0);
        check("rst_run_en", {31'd0, run_en}, 32'd1);
        check("rst_hour_val", {27'd0, hour_val}, 32'd0);
        check("rst_minute_val", {26'd0, minute_val}, 32'd0);
        check("rst_blink", {28'd0, blink_mask}, 32'd0);
        reset = 1'b1;
        wait_cycles(2);

        // Bounce: alternating level never settles, then a steady hold gives one press
        hour_in   = 5'd5;
        minute_in = 6'd17;
        for (int i = 0; i < 10; i++) begin
            btn_mode = (i % 2 == 0);
            wait_cycles(2);
        end
        check("bounce_no_press", {30'd0, mode_state}, 32'd0);
        btn_mode = 1'b1;
        wait_cycles(HOLD + 2);
        check("bounce_one_press", {30'd0, mode_state}, 32'd1);
        check("bounce_hour_cap", {27'd0, hour_val}, 32'd5);
        check("bounce_min_cap", {26'd0, minute_val}, 32'd17);
        check("set_run_en", {31'd0, run_en}, 32'd0);
        btn_mode = 1'b0;
        wait_cycles(HOLD);

        // Blink in SET_HOUR, then SET_MIN pattern with phase 0
        check("blink_entry", {28'd0, blink_mask}, 32'd0);
        do_tick();
        check("blink_t1", {28'd0, blink_mask}, 32'b1100);
        do_tick();
        check("blink_t2", {28'd0, blink_mask}, 32'b0000);
        press(1'b1, 1'b0);
        check("to_set_min", {30'd0, mode_state}, 32'd2);
        check("blink_min_entry", {28'd0, blink_mask}, 32'd0);
        do_tick();
        check("blink_min_t1", {28'd0, blink_mask}, 32'b0011);

        // Timeout: that tick was the first idle tick in SET_MIN
        do_tick();
        check("timeout_t2_state", {30'd0, mode_state}, 32'd2);
        do_tick();
        check("timeout_t3_state", {30'd0, mode_state}, 32'd0);
        check("timeout_run_en", {31'd0, run_en}, 32'd1);

        // Full set with wrap on both fields
        hour_in   = 5'd22;
        minute_in = 6'd58;
        press(1'b1, 1'b0);
        check("full_hour_cap", {27'd0, hour_val}, 32'd22);
        press(1'b0, 1'b1);
        check("full_hour_inc1", {27'd0, hour_val}, 32'd23);
        press(1'b0, 1'b1);
        check("full_hour_wrap", {27'd0, hour_val}, 32'd0);
        press(1'b1, 1'b0);
        check("full_to_min", {30'd0, mode_state}, 32'd2);
        for (int i = 0; i < 3; i++) press(1'b0, 1'b1);
        check("full_min_wrap", {26'd0, minute_val}, 32'd1);
        exp_q.push_back('{hour: 5'd0, minute: 6'd1});
        press(1'b1, 1'b0);
        check("full_after_state", {30'd0, mode_state}, 32'd0);
        check("full_after_run_en", {31'd0, run_en}, 32'd1);

        // Simultaneous mode+inc in SET_HOUR: mode wins
        hour_in   = 5'd10;
        minute_in = 6'd30;
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        check("simul_state", {30'd0, mode_state}, 32'd2);
        check("simul_hour", {27'd0, hour_val}, 32'd10);

        // Reset mid-edit
        press(1'b0, 1'b1);
        check("edit_min", {26'd0, minute_val}, 32'd31);
        #3 reset = 1'b0;
        #1;
        check("midrst_state", {30'd0, mode_state}, 32'd0);
        check("midrst_run_en", {31'd0, run_en}, 32'd1);
        check("midrst_loads", {30'd0, load_hour, load_minute}, 32'd0);
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(3);
        check("postrst_state", {30'd0, mode_state}, 32'd0);

`ifdef CLOCK_SET_AUTOREPEAT_EN
        // Auto-repeat: press + 3 repeats within 1 tick + 48 cycles
        hour_in = 5'd3;
        press(1'b1, 1'b0);
        btn_inc = 1'b1;
        wait_cycles(HOLD);
        do_tick();
        wait_cycles(47);
        btn_inc = 1'b0;
        wait_cycles(HOLD);
        check("autorep_hour", {27'd0, hour_val}, 32'd7);
`endif

        check("sb_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
